// File: rtl/axi_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_writer
//  Description : Collects a stream of data beats into a 16-entry buffer and
//                writes them out as AXI4 INCR bursts (AW -> W -> B). The write
//                address advances by the burst size after every completed
//                burst and wraps modulo 2^A_WIDTH.
//
//  Optional    : AXI_STREAM_WRITER_FLUSH_EN - when defined, s_flush writes out
//                a partially filled buffer as a short burst. When undefined,
//                s_flush is ignored and only full bursts are issued.
//
//  Ports       : aclk, aresetn         clock / async active-low reset
//                s_valid/s_ready/s_data stream input
//                s_flush               write out a partial burst
//                restart               return write address to 0
//                awvalid/awready/awaddr/awlen   AXI write-address channel
//                wvalid/wready/wlast/wdata      AXI write-data channel
//                bvalid/bready                  AXI write-response channel
//                busy                  high whenever not collecting beats
//                burst_cnt             number of completed bursts (wraps)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_writer #(
    parameter int         A_WIDTH   = 25,
    parameter int         D_WIDTH   = 16,
    parameter int         D_LEVEL   = 1,
    parameter logic [7:0] BURST_LEN = 8'd15
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [D_WIDTH-1:0] s_data,
    input  logic               s_flush,
    input  logic               restart,
    output logic               awvalid,
    input  logic               awready,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic               wvalid,
    input  logic               wready,
    output logic               wlast,
    output logic [D_WIDTH-1:0] wdata,
    input  logic               bvalid,
    output logic               bready,
    output logic               busy,
    output logic [15:0]        burst_cnt
);

    localparam logic [3:0] c_LAST_IDX = BURST_LEN[3:0];

    typedef enum logic [1:0] {
        FILL = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [D_WIDTH-1:0] r_buf [16];
    logic [3:0]         r_cnt;
    logic [3:0]         r_widx;
    logic [A_WIDTH-1:0] r_addr;
    logic [7:0]         r_awlen;
    logic [15:0]        r_burst_cnt;
    logic               r_restart_pend;
    // Holds s_ready low while in reset and releases it on the first clock.
    logic               r_out_en;

    logic               w_accept;
    logic               w_full;
    logic               w_flush_go;
    logic [7:0]         w_flush_len;
    logic               w_fill_exit;
    logic               w_w_hs;
    logic [A_WIDTH-1:0] w_addr_inc;

    // ------------------------------------------------------------------------
    // Output decode (purely from registered state)
    // ------------------------------------------------------------------------
    assign s_ready   = r_out_en && (r_state == FILL);
    assign awvalid   = (r_state == AW);
    assign wvalid    = (r_state == W);
    assign bready    = (r_state == B);
    assign busy      = (r_state != FILL);
    assign wlast     = (r_state == W) && (r_widx == r_awlen[3:0]);
    assign wdata     = r_buf[r_widx];
    assign awaddr    = r_addr;
    assign awlen     = r_awlen;
    assign burst_cnt = r_burst_cnt;

    // ------------------------------------------------------------------------
    // Handshake / transition conditions
    // ------------------------------------------------------------------------
    assign w_accept    = s_valid && s_ready;
    assign w_full      = w_accept && (r_cnt == c_LAST_IDX);
    assign w_w_hs      = wvalid && wready;
    // A beat accepted in the same cycle as the flush is part of the burst.
    assign w_flush_len = w_accept ? {4'd0, r_cnt} : {4'd0, r_cnt - 4'd1};

`ifdef AXI_STREAM_WRITER_FLUSH_EN
    assign w_flush_go  = s_flush && (r_state == FILL) && ((r_cnt != 4'd0) || w_accept);
`else
    logic w_unused_flush;
    assign w_unused_flush = s_flush;
    assign w_flush_go     = 1'b0;
`endif

    assign w_fill_exit = (r_state == FILL) && (w_full || w_flush_go);

    // Bytes covered by the current burst; truncation gives the modulo wrap.
    assign w_addr_inc  = A_WIDTH'({1'b0, r_awlen} + 9'd1) << D_LEVEL;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_fill_exit)      w_state_nxt = AW;
            AW:      if (awready)          w_state_nxt = W;
            W:       if (w_w_hs && wlast)  w_state_nxt = B;
            B:       if (bvalid)           w_state_nxt = FILL;
            default:                       w_state_nxt = FILL;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: counters, address, burst length, restart bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt          <= 4'd0;
            r_widx         <= 4'd0;
            r_addr         <= '0;
            r_awlen        <= 8'd0;
            r_burst_cnt    <= 16'd0;
            r_restart_pend <= 1'b0;
            r_out_en       <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                    if (restart) begin
                        r_addr <= '0;
                    end
                    if (w_full) begin
                        r_awlen <= BURST_LEN;
                    end else if (w_flush_go) begin
                        r_awlen <= w_flush_len;
                    end
                end
                AW: begin
                    if (awready) begin
                        r_widx <= 4'd0;
                    end
                    if (restart) begin
                        r_restart_pend <= 1'b1;
                    end
                end
                W: begin
                    if (w_w_hs) begin
                        r_widx <= r_widx + 4'd1;
                    end
                    if (restart) begin
                        r_restart_pend <= 1'b1;
                    end
                end
                B: begin
                    if (bvalid) begin
                        // A restart requested while busy takes effect here, on
                        // the way back into FILL, instead of the normal advance.
                        r_addr         <= (restart || r_restart_pend) ? '0 : r_addr + w_addr_inc;
                        r_burst_cnt    <= r_burst_cnt + 16'd1;
                        r_cnt          <= 4'd0;
                        r_restart_pend <= 1'b0;
                    end else if (restart) begin
                        r_restart_pend <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Beat buffer (no reset needed: contents are only read after being written)
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_buf[r_cnt] <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_stream_writer
//  Description : Self-checking bench for axi_stream_writer. A second instance
//                with a 6-bit address runs in lockstep to exercise address
//                wrap-around within a few bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_writer;

    localparam int         A_WIDTH = 25;
    localparam int         D_WIDTH = 16;
    localparam int         SA_W    = 6;

    logic               aclk    = 1'b0;
    logic               aresetn = 1'b1;
    logic               s_valid = 1'b0;
    logic [D_WIDTH-1:0] s_data  = '0;
    logic               s_flush = 1'b0;
    logic               restart = 1'b0;
    logic               awready = 1'b0;
    logic               wready  = 1'b0;
    logic               bvalid  = 1'b0;

    logic               s_ready, awvalid, wvalid, wlast, bready, busy;
    logic [A_WIDTH-1:0] awaddr;
    logic [7:0]         awlen;
    logic [D_WIDTH-1:0] wdata;
    logic [15:0]        burst_cnt;

    logic               s_ready_w, awvalid_w, wvalid_w, wlast_w, bready_w, busy_w;
    logic [SA_W-1:0]    awaddr_w;
    logic [7:0]         awlen_w;
    logic [D_WIDTH-1:0] wdata_w;
    logic [15:0]        burst_cnt_w;

    always #5 aclk = ~aclk;

    axi_stream_writer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_flush(s_flush), .restart(restart),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .busy(busy), .burst_cnt(burst_cnt)
    );

    axi_stream_writer #(.A_WIDTH(SA_W)) dut_w (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready_w), .s_data(s_data),
        .s_flush(s_flush), .restart(restart),
        .awvalid(awvalid_w), .awready(awready), .awaddr(awaddr_w), .awlen(awlen_w),
        .wvalid(wvalid_w), .wready(wready), .wlast(wlast_w), .wdata(wdata_w),
        .bvalid(bvalid), .bready(bready_w),
        .busy(busy_w), .burst_cnt(burst_cnt_w)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: next burst address and completed-burst count.
    logic [A_WIDTH-1:0] m_addr = '0;
    int                 m_bcnt = 0;

    // Observed traffic, recorded on the falling edge (handshakes that will
    // complete on the next rising edge).
    logic [D_WIDTH-1:0] acc_q[$];
    logic [D_WIDTH-1:0] wd_q[$];
    bit                 wl_q[$];
    logic [A_WIDTH-1:0] aw_addr_q[$];
    logic [7:0]         aw_len_q[$];
    logic [SA_W-1:0]    aw2_q[$];
    int                 b_n    = 0;
    int                 viol_n = 0;
    bit                 mon_wstall = 0, mon_awstall = 0;
    logic [D_WIDTH-1:0] mon_wprev;
    logic [A_WIDTH-1:0] mon_aprev;
    logic [7:0]         mon_lprev;

    always @(negedge aclk) begin
        if (!aresetn) begin
            mon_wstall  = 0;
            mon_awstall = 0;
        end else begin
            if (s_valid && s_ready) acc_q.push_back(s_data);
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                aw2_q.push_back(awaddr_w);
            end
            if (wvalid && wready) begin
                wd_q.push_back(wdata);
                wl_q.push_back(wlast);
            end
            if (bvalid && bready) b_n++;
            if ((int'(awvalid) + int'(wvalid) + int'(bready)) > 1) viol_n++;
            if (s_ready && busy) viol_n++;
            if (mon_wstall && (!wvalid || wdata !== mon_wprev)) viol_n++;
            if (mon_awstall && (!awvalid || awaddr !== mon_aprev || awlen !== mon_lprev)) viol_n++;
            mon_wstall  = wvalid && !wready;
            mon_wprev   = wdata;
            mon_awstall = awvalid && !awready;
            mon_aprev   = awaddr;
            mon_lprev   = awlen;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        acc_q.delete(); wd_q.delete(); wl_q.delete();
        aw_addr_q.delete(); aw_len_q.delete(); aw2_q.delete();
        b_n = 0; viol_n = 0;
    endtask

    // Offers n beats; incrementing data from base or random data.
    task automatic send_beats(input int n, input bit inc, input logic [15:0] base, output bit ok);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 300) begin
            s_valid = 1'b1;
            s_data  = inc ? base + 16'(sent) : 16'($urandom);
            if (s_ready) sent++;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        ok = (sent == n);
    endtask

    task automatic wait_bursts(input int n, output bit ok);
        int guard = 0;
        while (b_n < n && guard < 400) begin
            tick();
            guard++;
        end
        ok = (b_n >= n);
    endtask

    task automatic wait_wvalid(output bit ok);
        int guard = 0;
        while (!wvalid && guard < 100) begin
            tick();
            guard++;
        end
        ok = wvalid;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2 aresetn = 1'b0;
        @(negedge aclk);
        #2 aresetn = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        checks++; if (s_ready !== 1'b0)    begin errors++; $display("FAIL rst_s_ready got %0b want 0", s_ready); end
        checks++; if (awvalid !== 1'b0)    begin errors++; $display("FAIL rst_awvalid got %0b want 0", awvalid); end
        checks++; if (wvalid !== 1'b0)     begin errors++; $display("FAIL rst_wvalid got %0b want 0", wvalid); end
        checks++; if (wlast !== 1'b0)      begin errors++; $display("FAIL rst_wlast got %0b want 0", wlast); end
        checks++; if (bready !== 1'b0)     begin errors++; $display("FAIL rst_bready got %0b want 0", bready); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL rst_burst_cnt got %0d want 0", burst_cnt); end
        checks++; if (awaddr !== '0)       begin errors++; $display("FAIL rst_awaddr got %0h want 0", awaddr); end
        checks++; if (awlen !== 8'd0)      begin errors++; $display("FAIL rst_awlen got %0d want 0", awlen); end
        @(negedge aclk);
        #2 aresetn = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rel_s_ready_pre got %0b want 0", s_ready); end
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready_post got %0b want 1", s_ready); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic();
        bit ok;
        clear_mon();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        send_beats(16, 1'b1, 16'h0000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_send got timeout want 16 beats"); end
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL basic_aw_latency got awvalid=%0b want 1", awvalid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_busy got %0b want 0", s_ready); end
        wait_bursts(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_bresp got %0d bursts want 1", b_n); end
        checks++; if (aw_addr_q.size() != 1 || aw_addr_q[0] !== '0 || aw_len_q[0] !== 8'd15)
            begin errors++; $display("FAIL basic_aw got n=%0d addr=%0h len=%0d want addr=0 len=15", aw_addr_q.size(), aw_addr_q.size() ? aw_addr_q[0] : '0, aw_len_q.size() ? aw_len_q[0] : 8'd0); end
        checks++; if (wd_q.size() != 16) begin errors++; $display("FAIL basic_wcount got %0d want 16", wd_q.size()); end
        for (int i = 0; i < wd_q.size() && i < 16; i++) begin
            checks++; if (wd_q[i] !== 16'(i) || wl_q[i] !== (i == 15))
                begin errors++; $display("FAIL basic_wbeat%0d got data=%0h last=%0b want data=%0h last=%0b", i, wd_q[i], wl_q[i], i, (i == 15)); end
        end
        m_addr = m_addr + 25'h20; m_bcnt++;
        checks++; if (burst_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL basic_burst_cnt got %0d want %0d", burst_cnt, m_bcnt); end
        checks++; if (awaddr !== m_addr) begin errors++; $display("FAIL basic_next_addr got %0h want %0h", awaddr, m_addr); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stall();
        bit ok;
        clear_mon();
        awready = 1'b1; wready = 1'b0; bvalid = 1'b1;
        send_beats(16, 1'b0, 16'h0, ok);
        wait_wvalid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_wvalid got timeout want wvalid"); end
        wready = 1'b1;
        repeat (4) tick();
        wready = 1'b0;
        checks++; if (wd_q.size() != 4) begin errors++; $display("FAIL stall_pre_count got %0d want 4", wd_q.size()); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (wvalid !== 1'b1 || wdata !== acc_q[4] || s_ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold%0d got wvalid=%0b wdata=%0h s_ready=%0b want 1 %0h 0", c, wvalid, wdata, s_ready, acc_q[4]); end
            tick();
        end
        wready = 1'b1;
        wait_bursts(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_bresp got %0d want 1", b_n); end
        checks++; if (wd_q.size() != 16 || acc_q.size() != 16) begin errors++; $display("FAIL stall_count got %0d/%0d want 16", wd_q.size(), acc_q.size()); end
        for (int i = 0; i < wd_q.size() && i < acc_q.size(); i++) begin
            checks++; if (wd_q[i] !== acc_q[i]) begin errors++; $display("FAIL stall_beat%0d got %0h want %0h", i, wd_q[i], acc_q[i]); end
        end
        checks++; if (aw_addr_q.size() != 1 || aw_addr_q[0] !== m_addr) begin errors++; $display("FAIL stall_awaddr got %0h want %0h", aw_addr_q.size() ? aw_addr_q[0] : '0, m_addr); end
        checks++; if (viol_n != 0) begin errors++; $display("FAIL stall_protocol got %0d violations want 0", viol_n); end
        m_addr = m_addr + 25'h20; m_bcnt++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        bit ok;
        int guard = 0;
        logic [A_WIDTH-1:0] a0 = m_addr;
        clear_mon();
        while (b_n < 3 && guard < 3000) begin
            s_valid = (acc_q.size() < 48) && ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            awready = ($urandom_range(0, 2) != 0);
            wready  = ($urandom_range(0, 3) != 0);
            bvalid  = ($urandom_range(0, 1) != 0);
            tick();
            guard++;
        end
        s_valid = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        ok = (b_n == 3);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_bursts got %0d want 3", b_n); end
        checks++; if (aw_addr_q.size() != 3) begin errors++; $display("FAIL b2b_aw_count got %0d want 3", aw_addr_q.size()); end
        for (int k = 0; k < aw_addr_q.size() && k < 3; k++) begin
            checks++; if (aw_addr_q[k] !== a0 + A_WIDTH'(32 * k) || aw_len_q[k] !== 8'd15)
                begin errors++; $display("FAIL b2b_aw%0d got addr=%0h len=%0d want addr=%0h len=15", k, aw_addr_q[k], aw_len_q[k], a0 + A_WIDTH'(32 * k)); end
        end
        checks++; if (wd_q.size() != 48 || acc_q.size() != 48) begin errors++; $display("FAIL b2b_count got %0d/%0d want 48", wd_q.size(), acc_q.size()); end
        for (int i = 0; i < wd_q.size() && i < acc_q.size(); i++) begin
            checks++; if (wd_q[i] !== acc_q[i] || wl_q[i] !== ((i % 16) == 15))
                begin errors++; $display("FAIL b2b_beat%0d got data=%0h last=%0b want data=%0h last=%0b", i, wd_q[i], wl_q[i], acc_q[i], ((i % 16) == 15)); end
        end
        m_addr = a0 + 25'h60; m_bcnt += 3;
        checks++; if (burst_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL b2b_burst_cnt got %0d want %0d", burst_cnt, m_bcnt); end
        checks++; if (viol_n != 0) begin errors++; $display("FAIL b2b_protocol got %0d violations want 0", viol_n); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_restart();
        bit ok;
        clear_mon();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        send_beats(16, 1'b0, 16'h0, ok);
        wait_bursts(1, ok);
        m_addr = m_addr + 25'h20;
        wready = 1'b0;
        send_beats(16, 1'b0, 16'h0, ok);
        wait_wvalid(ok);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wready = 1'b1;
        wait_bursts(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst2_bresp got %0d want 2", b_n); end
        checks++; if (aw_addr_q.size() < 2 || aw_addr_q[1] !== m_addr) begin errors++; $display("FAIL rst2_aw_unmodified got %0h want %0h", aw_addr_q.size() > 1 ? aw_addr_q[1] : '0, m_addr); end
        m_addr = '0;
        checks++; if (awaddr !== m_addr) begin errors++; $display("FAIL rst2_idle_addr got %0h want 0", awaddr); end
        send_beats(16, 1'b0, 16'h0, ok);
        wait_bursts(3, ok);
        checks++; if (aw_addr_q.size() < 3 || aw_addr_q[2] !== '0) begin errors++; $display("FAIL rst2_next_aw got %0h want 0", aw_addr_q.size() > 2 ? aw_addr_q[2] : '0); end
        m_addr = 25'h20;
        // Restart while collecting: address returns to 0, buffered beats kept.
        send_beats(5, 1'b0, 16'h0, ok);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (awaddr !== '0) begin errors++; $display("FAIL rstf_addr got %0h want 0", awaddr); end
        send_beats(11, 1'b0, 16'h0, ok);
        wait_bursts(4, ok);
        checks++; if (aw_addr_q.size() < 4 || aw_addr_q[3] !== '0) begin errors++; $display("FAIL rstf_aw got %0h want 0", aw_addr_q.size() > 3 ? aw_addr_q[3] : '0); end
        checks++; if (wd_q.size() != 64 || acc_q.size() != 64) begin errors++; $display("FAIL rstf_count got %0d/%0d want 64", wd_q.size(), acc_q.size()); end
        for (int i = 48; i < wd_q.size() && i < acc_q.size(); i++) begin
            checks++; if (wd_q[i] !== acc_q[i]) begin errors++; $display("FAIL rstf_beat%0d got %0h want %0h", i, wd_q[i], acc_q[i]); end
        end
        m_addr = 25'h20; m_bcnt += 4;
        checks++; if (burst_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL rstf_burst_cnt got %0d want %0d", burst_cnt, m_bcnt); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_flush();
        bit ok;
        clear_mon();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
`ifdef AXI_STREAM_WRITER_FLUSH_EN
        s_flush = 1'b1;
        repeat (3) tick();
        s_flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_empty got busy=%0b want 0", busy); end
        send_beats(3, 1'b0, 16'h0, ok);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        wait_bursts(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_bresp got %0d want 1", b_n); end
        checks++; if (aw_len_q.size() != 1 || aw_len_q[0] !== 8'd2 || aw_addr_q[0] !== m_addr)
            begin errors++; $display("FAIL flush_aw got len=%0d addr=%0h want len=2 addr=%0h", aw_len_q.size() ? aw_len_q[0] : 8'd0, aw_addr_q.size() ? aw_addr_q[0] : '0, m_addr); end
        checks++; if (wd_q.size() != 3) begin errors++; $display("FAIL flush_wcount got %0d want 3", wd_q.size()); end
        for (int i = 0; i < wd_q.size() && i < acc_q.size(); i++) begin
            checks++; if (wd_q[i] !== acc_q[i] || wl_q[i] !== (i == 2))
                begin errors++; $display("FAIL flush_beat%0d got data=%0h last=%0b want data=%0h last=%0b", i, wd_q[i], wl_q[i], acc_q[i], (i == 2)); end
        end
        m_addr = m_addr + 25'd6; m_bcnt++;
        checks++; if (awaddr !== m_addr) begin errors++; $display("FAIL flush_next_addr got %0h want %0h", awaddr, m_addr); end
`else
        send_beats(3, 1'b0, 16'h0, ok);
        s_flush = 1'b1;
        repeat (4) tick();
        s_flush = 1'b0;
        checks++; if (busy !== 1'b0 || aw_addr_q.size() != 0) begin errors++; $display("FAIL noflush_ignored got busy=%0b aw=%0d want 0 0", busy, aw_addr_q.size()); end
        send_beats(13, 1'b0, 16'h0, ok);
        wait_bursts(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL noflush_bresp got %0d want 1", b_n); end
        checks++; if (aw_len_q.size() != 1 || aw_len_q[0] !== 8'd15 || aw_addr_q[0] !== m_addr)
            begin errors++; $display("FAIL noflush_aw got len=%0d addr=%0h want len=15 addr=%0h", aw_len_q.size() ? aw_len_q[0] : 8'd0, aw_addr_q.size() ? aw_addr_q[0] : '0, m_addr); end
        checks++; if (wd_q.size() != 16 || acc_q.size() != 16) begin errors++; $display("FAIL noflush_count got %0d/%0d want 16", wd_q.size(), acc_q.size()); end
        for (int i = 0; i < wd_q.size() && i < acc_q.size(); i++) begin
            checks++; if (wd_q[i] !== acc_q[i]) begin errors++; $display("FAIL noflush_beat%0d got %0h want %0h", i, wd_q[i], acc_q[i]); end
        end
        m_addr = m_addr + 25'h20; m_bcnt++;
`endif
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        awready = 1'b1; wready = 1'b0; bvalid = 1'b1;
        send_beats(16, 1'b0, 16'h0, ok);
        wait_wvalid(ok);
        tick();
        tick();
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({s_ready, awvalid, wvalid, wlast, bready, busy} !== 6'b0)
            begin errors++; $display("FAIL midrst_outputs got %b want 000000", {s_ready, awvalid, wvalid, wlast, bready, busy}); end
        checks++; if (burst_cnt !== 16'd0 || awaddr !== '0 || awlen !== 8'd0)
            begin errors++; $display("FAIL midrst_regs got cnt=%0d addr=%0h len=%0d want 0 0 0", burst_cnt, awaddr, awlen); end
        wready = 1'b1;
        @(negedge aclk);
        #2 aresetn = 1'b1;
        tick();
        m_addr = '0; m_bcnt = 0;
        clear_mon();
        send_beats(16, 1'b0, 16'h0, ok);
        wait_bursts(1, ok);
        checks++; if (!ok || aw_addr_q.size() != 1 || aw_addr_q[0] !== '0)
            begin errors++; $display("FAIL midrst_clean_aw got n=%0d addr=%0h want 1 0", aw_addr_q.size(), aw_addr_q.size() ? aw_addr_q[0] : '0); end
        checks++; if (wd_q.size() != 16 || acc_q.size() != 16) begin errors++; $display("FAIL midrst_count got %0d/%0d want 16", wd_q.size(), acc_q.size()); end
        for (int i = 0; i < wd_q.size() && i < acc_q.size(); i++) begin
            checks++; if (wd_q[i] !== acc_q[i]) begin errors++; $display("FAIL midrst_beat%0d got %0h want %0h", i, wd_q[i], acc_q[i]); end
        end
        m_addr = 25'h20; m_bcnt = 1;
        checks++; if (burst_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL midrst_burst_cnt got %0d want %0d", burst_cnt, m_bcnt); end
    endtask

    // ------------------------------------------------------------------------
    // The 6-bit instance reaches the top of its address space after one burst,
    // so the burst there is issued at 64-32 and the following one at 0.
    task automatic test_wrap();
        bit ok;
        do_reset();
        clear_mon();
        m_addr = '0; m_bcnt = 0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_beats(16, 1'b0, 16'h0, ok);
            wait_bursts(k + 1, ok);
        end
        checks++; if (aw2_q.size() != 3 || aw_addr_q.size() != 3) begin errors++; $display("FAIL wrap_count got %0d/%0d want 3", aw2_q.size(), aw_addr_q.size()); end
        for (int k = 0; k < aw2_q.size() && k < 3; k++) begin
            checks++; if (aw2_q[k] !== SA_W'((32 * k) % 64) || aw_addr_q[k] !== A_WIDTH'(32 * k))
                begin errors++; $display("FAIL wrap_aw%0d got small=%0h big=%0h want small=%0h big=%0h", k, aw2_q[k], aw_addr_q[k], (32 * k) % 64, 32 * k); end
        end
        checks++; if (awaddr_w !== SA_W'(96 % 64)) begin errors++; $display("FAIL wrap_next got %0h want %0h", awaddr_w, 96 % 64); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_restart();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
